// File: rtl/coin_pulse_generator_pkg.sv
// Shared types and default pulse widths for the coin-sensor transmit path.
// width_of() is also used by benches that drive or measure coin pulses.
package coin_pulse_generator_pkg;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_NICKEL  = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DIME_W_DEF    = 3;
    localparam int NICKEL_W_DEF  = 7;
    localparam int QUARTER_W_DEF = 11;
    localparam int GAP_W_DEF     = 2;

    function automatic int width_of(coin_t coin);
        case (coin)
            COIN_DIME:    return DIME_W_DEF;
            COIN_NICKEL:  return NICKEL_W_DEF;
            COIN_QUARTER: return QUARTER_W_DEF;
            default:      return 0;
        endcase
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/coin_pulse_generator_if.sv
// Request handshake and sensor-side status of the coin pulse generator.
// master = request producer / observer, slave = the generator itself.
interface coin_pulse_generator_if;
    import coin_pulse_generator_pkg::*;

    logic  reqValid;
    coin_t reqCoin;
    logic  reqReady;
    logic  coinSensor;
    logic  busy;
    logic  done;
    logic  badReq;

    modport master (
        output reqValid, reqCoin,
        input  reqReady, coinSensor, busy, done, badReq
    );

    modport slave (
        input  reqValid, reqCoin,
        output reqReady, coinSensor, busy, done, badReq
    );

endinterface

// File: rtl/coin_pulse_generator_req_fifo.sv
// Two-entry request buffer (read pointer + count) with asynchronous reset.
// The caller guarantees no push when full and no pop when empty.
module coin_pulse_generator_req_fifo
    import coin_pulse_generator_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  coin_t push_coin,
    input  logic  pop,
    output coin_t head,
    output logic  full,
    output logic  empty
);

    coin_t      mem [2];
    logic       rd_ptr;
    logic [1:0] count;
    logic       wr_idx;

    // With one entry stored the free slot is the one opposite the read pointer.
    assign wr_idx = rd_ptr ^ count[0];
    assign head   = mem[rd_ptr];
    assign full   = (count == 2'd2);
    assign empty  = (count == 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= COIN_NONE;
            mem[1] <= COIN_NONE;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_coin;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/coin_pulse_generator.sv
// Turns buffered coin requests into coinSensor pulses whose high width encodes
// the coin type, each followed by a forced low gap.
module coin_pulse_generator
    import coin_pulse_generator_pkg::*;
#(
    parameter int DIME_W    = DIME_W_DEF,
    parameter int NICKEL_W  = NICKEL_W_DEF,
    parameter int QUARTER_W = QUARTER_W_DEF,
    parameter int GAP_W     = GAP_W_DEF
)
(
    input  logic clk,
    input  logic reset,
    coin_pulse_generator_if.slave bus
);

    localparam int CNT_W = $clog2(max2(QUARTER_W, GAP_W) + 1);

    if (DIME_W < 1 || NICKEL_W < 1 || QUARTER_W < 1 || GAP_W < 1) begin : g_bad_width
        $error("coin_pulse_generator: every pulse/gap width must be at least 1");
    end

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               pop;
    logic               done_d;
    logic               accept;
    logic               is_none;
    logic               push;
    logic               full;
    logic               empty;
    coin_t              head;
    logic               sensor_q;
    logic               done_q;
    logic               bad_q;

    function automatic logic [CNT_W-1:0] load_width(coin_t coin);
        case (coin)
            COIN_DIME:    return CNT_W'(DIME_W - 1);
            COIN_NICKEL:  return CNT_W'(NICKEL_W - 1);
            COIN_QUARTER: return CNT_W'(QUARTER_W - 1);
            default:      return '0;
        endcase
    endfunction

    // Invalid coins complete the handshake but never enter the buffer.
    assign accept  = bus.reqValid & bus.reqReady;
    assign is_none = (bus.reqCoin == COIN_NONE);
    assign push    = accept & ~is_none;

    coin_pulse_generator_req_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_coin (bus.reqCoin),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_d   = load_width(head);
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(GAP_W - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are registered off the FSM, so the pin trails the state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sensor_q <= 1'b0;
            done_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            sensor_q <= (state_q == PULSE);
            done_q   <= done_d;
            bad_q    <= accept & is_none;
        end
    end

    assign bus.reqReady   = ~full;
    assign bus.coinSensor = sensor_q;
    assign bus.done       = done_q;
    assign bus.badReq     = bad_q;
    assign bus.busy       = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_coin_pulse_generator.sv
// Directed bench for coin_pulse_generator with a pulse-width monitor that
// stands in for the CoinDetector (dime 2..4, nickel 6..8, quarter 10..12).
module tb_coin_pulse_generator;
    import coin_pulse_generator_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    coin_pulse_generator_if bus ();

    coin_pulse_generator #(
        .DIME_W    (3),
        .NICKEL_W  (7),
        .QUARTER_W (11),
        .GAP_W     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int check_count = 0;
    int pass_count  = 0;

    int hi_run = 0;
    int lo_run = 0;
    int done_count = 0;
    int dime_hits = 0;
    int nickel_hits = 0;
    int quarter_hits = 0;
    int other_hits = 0;
    bit seen_pulse = 1'b0;
    int hi_widths [$];
    int lo_widths [$];

    // Measures high/low run lengths on coinSensor and classifies each completed pulse.
    always @(negedge clk) begin
        if (reset) begin
            hi_run = 0;
            lo_run = 0;
        end else begin
            if (bus.coinSensor === 1'b1) begin
                if (lo_run > 0 && seen_pulse) lo_widths.push_back(lo_run);
                lo_run = 0;
                hi_run++;
            end else begin
                if (hi_run > 0) begin
                    hi_widths.push_back(hi_run);
                    if (hi_run >= 2 && hi_run <= 4) dime_hits++;
                    else if (hi_run >= 6 && hi_run <= 8) nickel_hits++;
                    else if (hi_run >= 10 && hi_run <= 12) quarter_hits++;
                    else other_hits++;
                    seen_pulse = 1'b1;
                end
                hi_run = 0;
                lo_run++;
            end
            if (bus.done === 1'b1) done_count++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input coin_t coin);
        bus.reqValid = valid;
        bus.reqCoin  = coin;
        step(1);
    endtask

    task automatic idleInputs();
        bus.reqValid = 1'b0;
        bus.reqCoin  = COIN_NONE;
    endtask

    task automatic waitDones(input int target, input int limit, input string tag);
        int n = 0;
        while (done_count < target && n < limit) begin
            step(1);
            n++;
        end
        checkOutput(tag, done_count, target);
    endtask

    initial begin
        bit exp_sense [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        bit exp_done  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        bit exp_busy  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        int base_hi, base_lo, base_done;
        int base_dime, base_nickel, base_quarter, base_other;

        // Reset held for two cycles, then quiet outputs.
        reset = 1'b1;
        idleInputs();
        step(2);
        checkOutput("rst_sensor", bus.coinSensor, 1'b0);
        checkOutput("rst_ready", bus.reqReady, 1'b1);
        checkOutput("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checkOutput("idle_sensor", bus.coinSensor, 1'b0);
            checkOutput("idle_ready", bus.reqReady, 1'b1);
            checkOutput("idle_busy", bus.busy, 1'b0);
        end

        // Single dime: high after edges k+2..k+4, done after k+6.
        applyStimulus(1'b1, COIN_DIME);
        idleInputs();
        checkOutput("dime_ready", bus.reqReady, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("dime_sensor_k%0d", i), bus.coinSensor, exp_sense[i]);
            checkOutput($sformatf("dime_done_k%0d", i), bus.done, exp_done[i]);
            checkOutput($sformatf("dime_busy_k%0d", i), bus.busy, exp_busy[i]);
            step(1);
        end

        // Invalid coin: accepted, flagged, never pulsed.
        base_done = done_count;
        applyStimulus(1'b1, COIN_NONE);
        idleInputs();
        checkOutput("bad_pulse", bus.badReq, 1'b1);
        checkOutput("bad_ready", bus.reqReady, 1'b1);
        checkOutput("bad_busy", bus.busy, 1'b0);
        step(1);
        checkOutput("bad_clear", bus.badReq, 1'b0);
        checkOutput("bad_busy2", bus.busy, 1'b0);
        step(3);
        checkOutput("bad_sensor", bus.coinSensor, 1'b0);
        checkOutput("bad_nodone", done_count, base_done);

        // Nickel, quarter, dime on consecutive cycles.
        base_hi = hi_widths.size();
        base_lo = lo_widths.size();
        base_done = done_count;
        applyStimulus(1'b1, COIN_NICKEL);
        checkOutput("b2b_ready1", bus.reqReady, 1'b1);
        applyStimulus(1'b1, COIN_QUARTER);
        checkOutput("b2b_ready2", bus.reqReady, 1'b1);
        applyStimulus(1'b1, COIN_DIME);
        idleInputs();
        checkOutput("b2b_full", bus.reqReady, 1'b0);
        step(3);
        checkOutput("b2b_held", bus.reqReady, 1'b0);
        waitDones(base_done + 3, 80, "b2b_dones");
        step(2);
        checkOutput("b2b_npulses", hi_widths.size() - base_hi, 3);
        checkOutput("b2b_w_nickel", hi_widths[base_hi], 7);
        checkOutput("b2b_w_quarter", hi_widths[base_hi + 1], 11);
        checkOutput("b2b_w_dime", hi_widths[base_hi + 2], 3);
        checkOutput("b2b_nlows", lo_widths.size() - base_lo, 3);
        checkOutput("b2b_gap1", lo_widths[base_lo + 1], 3);
        checkOutput("b2b_gap2", lo_widths[base_lo + 2], 3);
        checkOutput("b2b_busy_end", bus.busy, 1'b0);

        // Reset four cycles into a quarter pulse with a dime queued behind it.
        applyStimulus(1'b1, COIN_QUARTER);
        applyStimulus(1'b1, COIN_DIME);
        idleInputs();
        step(4);
        checkOutput("mid_sensor_high", bus.coinSensor, 1'b1);
        base_hi = hi_widths.size();
        reset = 1'b1;
        #1;
        checkOutput("mid_sensor_async", bus.coinSensor, 1'b0);
        checkOutput("mid_ready", bus.reqReady, 1'b1);
        checkOutput("mid_busy", bus.busy, 1'b0);
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            checkOutput("mid_flushed_sensor", bus.coinSensor, 1'b0);
            checkOutput("mid_flushed_busy", bus.busy, 1'b0);
        end
        base_done = done_count;
        applyStimulus(1'b1, COIN_DIME);
        idleInputs();
        waitDones(base_done + 1, 20, "mid_dime_done");
        checkOutput("mid_npulses", hi_widths.size() - base_hi, 1);
        checkOutput("mid_dime_width", hi_widths[base_hi], 3);

        // Loopback classification, one coin of each type.
        base_dime = dime_hits;
        base_nickel = nickel_hits;
        base_quarter = quarter_hits;
        base_other = other_hits;
        base_done = done_count;
        applyStimulus(1'b1, COIN_DIME);
        idleInputs();
        waitDones(base_done + 1, 20, "det_dime_done");
        checkOutput("det_dime_d", dime_hits - base_dime, 1);
        checkOutput("det_dime_n", nickel_hits - base_nickel, 0);
        checkOutput("det_dime_q", quarter_hits - base_quarter, 0);
        applyStimulus(1'b1, COIN_NICKEL);
        idleInputs();
        waitDones(base_done + 2, 30, "det_nickel_done");
        checkOutput("det_nickel_d", dime_hits - base_dime, 1);
        checkOutput("det_nickel_n", nickel_hits - base_nickel, 1);
        checkOutput("det_nickel_q", quarter_hits - base_quarter, 0);
        applyStimulus(1'b1, COIN_QUARTER);
        idleInputs();
        waitDones(base_done + 3, 40, "det_quarter_done");
        checkOutput("det_quarter_d", dime_hits - base_dime, 1);
        checkOutput("det_quarter_n", nickel_hits - base_nickel, 1);
        checkOutput("det_quarter_q", quarter_hits - base_quarter, 1);
        checkOutput("det_other", other_hits - base_other, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
